// File: rtl/enc_bin2onehot_stream.sv
// Streaming binary-to-one-hot/thermometer encoder with a 2-entry output FIFO.
// Out-of-range codes store an all-zero vector with an error flag and bump a saturating counter.
module enc_bin2onehot_stream #(
  parameter int W = 4,
  parameter int N = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         out_err,
  output logic [7:0]   err_cnt
);

  typedef struct packed {
    logic [N-1:0] vec;
    logic         err;
  } entry_t;

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     new_entry;
  logic [1:0] occ_q, occ_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       push;
  logic       pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    new_entry = '0;
    if (int'(in) >= N) begin
      new_entry.err = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        new_entry.vec[k] = in_mode ? (k <= int'(in)) : (k == int'(in));
      end
    end
  end

  // Ready comes only from registered occupancy and the reset pin, never from out_ready.
  assign in_ready  = rst && (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = new_entry;
        else               tail_d = new_entry;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      // A push is only possible below full, so push+pop always starts at occupancy 1.
      2'b11: begin
        head_d = new_entry;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && new_entry.err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  // NOTE: the two FIFO slots are reset too; it is cheap and keeps head contents deterministic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= 2'd0;
      err_cnt_q <= 8'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out     = out_valid ? head_q.vec : '0;
  assign out_err = out_valid ? head_q.err : 1'b0;
  assign err_cnt = err_cnt_q;

endmodule
